instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, 4, PC increment per accepted instruction.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  one-cycle request pulse; imem_addr valid that cycle.
REQ-006 imem_addr  out  32  fetch address; equals current PC.
REQ-007 imem_rdata  in  32  instruction word, valid when imem_valid=1.
REQ-008 imem_valid  in  1  response strobe; arrives at least 1 cycle after imem_req.
REQ-009 stall  in  1  downstream not consuming; held instruction must not change.
REQ-010 redirect  in  1  taken branch/jump; overrides all other events.
REQ-011 redirect_pc  in  32  new PC, sampled when redirect=1.
REQ-012 instr  out  32  registered instruction word.
REQ-013 opCode  out  7  instr[6:0], combinational from instr register; feeds the control unit.
REQ-014 instr_valid  out  1  instr/pc_out hold a live instruction.
REQ-015 pc_out  out  32  address of the instruction in instr.

Function
REQ-016 States: IDLE (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 IDLE, redirect=0: imem_req=1 iff instr_valid=0 or stall=0; on issue -> WAIT.
REQ-019 IDLE, redirect=0, instr_valid=1 and stall=0: instr_valid SHALL clear that edge (instruction consumed).
REQ-020 WAIT, imem_valid=1, redirect=0: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+PC_STEP (mod 2^32), -> IDLE.
REQ-021 WAIT, imem_valid=0, redirect=0: no req, hold state; instr_valid clears if consumed (stall=0).
REQ-022 Any state, redirect=1: pc<=redirect_pc, instr_valid<=0, imem_req=0 that cycle.
REQ-023 redirect=1 in IDLE -> IDLE; in WAIT with imem_valid=1 -> IDLE, response discarded; in WAIT with imem_valid=0 -> DROP.
REQ-024 DROP: imem_req=0; imem_valid=1 -> response discarded, -> IDLE; repeated redirect updates pc, stays DROP.
REQ-025 With instr_valid=1 and stall=1, instr, pc_out, instr_valid SHALL remain unchanged unless redirect=1.
REQ-026 PC wrap: 32'hFFFF_FFFC + 4 SHALL yield 32'h0000_0000, no flag.
REQ-027 Peak throughput: one instruction per 2 cycles with 1-cycle memory latency.
REQ-028 imem_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, pc=RESET_PC, instr=0 (opCode=0, no-op decode), pc_out=0, instr_valid=0, imem_req=0.
REQ-030 Reset asserted mid-request discards that request; the first request after release is to RESET_PC.
REQ-031 First imem_req SHALL occur in the first cycle after rst_n deasserts.

Structure
REQ-032 Shared package holds state encoding (IDLE/WAIT/DROP), XLEN=32, OPCODE_W=7, default RESET_PC.
REQ-033 Single module, no sub-modules; PC register and FSM inline.

Verification
REQ-034 Reset release, memory latency 1, stall=0 -> requests to 0x0,0x4,0x8 on cycles 1,3,5; instr_valid pulses with matching pc_out.
REQ-035 Word 0x00000001 fetched -> opCode=7'b0000001, instr_valid=1; stall=1 for 5 cycles -> instr unchanged, no imem_req.
REQ-036 Request to 0x8 outstanding, redirect=1 redirect_pc=0x40, response arrives 3 cycles later -> response dropped, next imem_addr=0x40, pc_out never 0x8.
REQ-037 redirect coincident with imem_valid -> word discarded, instr_valid=0, next fetch at redirect_pc.
REQ-038 redirect_pc=0xFFFFFFFC -> fetched pc_out=0xFFFFFFFC, next imem_addr=0x00000000.
REQ-039 rst_n low during WAIT -> outputs zero asynchronously; late imem_valid ignored; first request after release to RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN             - datapath / address width
//   OPCODE_W         - width of the opcode field at the bottom of an instruction
//   DEFAULT_RESET_PC - default PC loaded on reset
//   fetch_state_e    - fetch FSM encoding (idle / request outstanding / drop response)
package instr_fetch_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPCODE_W = 7;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,  // free to issue a request
        StWait = 2'd1,  // one request outstanding, response will be kept
        StDrop = 2'd2   // one request outstanding, response will be discarded
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps the PC, issues single-outstanding requests to
// instruction memory and holds the fetched word until downstream consumes it.
//
// Parameters
//   RESET_PC    - PC loaded on reset
//   PC_STEP     - PC increment per accepted instruction
// Ports
//   clk, rst_n  - clock, asynchronous active-low reset
//   imem_req    - one-cycle request pulse, imem_addr valid in that cycle
//   imem_addr   - fetch address (current PC)
//   imem_rdata  - instruction word from memory, valid with imem_valid
//   imem_valid  - memory response strobe
//   stall       - downstream is not consuming the held instruction
//   redirect    - taken branch/jump, overrides everything else
//   redirect_pc - new PC, sampled with redirect
//   instr       - held instruction word
//   opCode      - instr[6:0], for the control unit
//   instr_valid - instr/pc_out hold a live instruction
//   pc_out      - address of the held instruction
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [XLEN-1:0]     imem_rdata,
    input  logic                imem_valid,
    input  logic                stall,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic [XLEN-1:0]     instr,
    output logic [OPCODE_W-1:0] opCode,
    output logic                instr_valid,
    output logic [XLEN-1:0]     pc_out
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            instr_valid_q, instr_valid_d;
    logic            consumed;
    logic            issue;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        issue         = 1'b0;
        consumed      = instr_valid_q && !stall;

        if (redirect) begin
            pc_d          = redirect_pc;
            instr_valid_d = 1'b0;
            // A request still in flight must have its response thrown away.
            if (state_q != StIdle && !imem_valid) begin
                state_d = StDrop;
            end else begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (consumed) begin
                        instr_valid_d = 1'b0;
                    end
                    if (!instr_valid_q || !stall) begin
                        issue   = 1'b1;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_valid) begin
                        instr_d       = imem_rdata;
                        pc_out_d      = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + XLEN'(PC_STEP);
                        state_d       = StIdle;
                    end else if (consumed) begin
                        instr_valid_d = 1'b0;
                    end
                end
                StDrop: begin
                    if (consumed) begin
                        instr_valid_d = 1'b0;
                    end
                    if (imem_valid) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Gated by rst_n so no request escapes while reset is held (state is idle then).
    assign imem_req    = issue && rst_n;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opCode      = instr_q[OPCODE_W-1:0];
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [6:0]  opCode;
    logic        instr_valid;
    logic [31:0] pc_out;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .opCode      (opCode),
        .instr_valid (instr_valid),
        .pc_out      (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of directed stimulus plus the outputs expected during that cycle.
    typedef struct {
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        bit          mv;
        logic [31:0] md;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pco;
        logic [31:0] e_ins;
    } vec_t;

    function automatic vec_t mk(bit st, bit rd, logic [31:0] rpc, bit mv, logic [31:0] md,
                                bit req, logic [31:0] addr, bit iv, logic [31:0] pco,
                                logic [31:0] ins);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.mv = mv; v.md = md;
        v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_pco = pco; v.e_ins = ins;
        return v;
    endfunction

    vec_t        vecs [24];
    logic [6:0]  exp_op;

    // Reference model state (transaction level) and memory responder.
    logic [31:0] m_pc, m_instr, m_pcout;
    bit          m_held, m_out, m_discard;
    bit          exp_req, consumed, got, resp, pend;
    int          cnt;

    task automatic drive_idle();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();

        //         st rd rpc           mv md            req addr          iv pc_out        instr
        vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 32'h11111113, 0, 32'h0,        0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h11111113);
        vecs[3]  = mk(0, 0, 32'h0,        1, 32'h22222223, 0, 32'h4,        0, 32'h0,        32'h11111113);
        vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h22222223);
        vecs[5]  = mk(0, 0, 32'h0,        1, 32'h00000001, 0, 32'h8,        0, 32'h4,        32'h22222223);
        vecs[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 32'h8,        32'h1);
        vecs[7]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 32'h8,        32'h1);
        vecs[8]  = mk(1, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'hC,        1, 32'h8,        32'h1);
        vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 32'h8,        32'h1);
        vecs[10] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 32'h8,        32'h1);
        vecs[11] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        1, 32'h8,        32'h1);
        vecs[12] = mk(0, 1, 32'h100,      1, 32'h33,       0, 32'hC,        0, 32'h8,        32'h1);
        vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h8,        32'h1);
        vecs[14] = mk(0, 1, 32'h40,       0, 32'h0,        0, 32'h100,      0, 32'h8,        32'h1);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h40,       0, 32'h8,        32'h1);
        vecs[16] = mk(0, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h40,       0, 32'h8,        32'h1);
        vecs[17] = mk(0, 0, 32'h0,        1, 32'h44,       0, 32'hFFFFFFFC, 0, 32'h8,        32'h1);
        vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h8,        32'h1);
        vecs[19] = mk(0, 0, 32'h0,        1, 32'h37,       0, 32'hFFFFFFFC, 0, 32'h8,        32'h1);
        vecs[20] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 32'h37);
        vecs[21] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC, 32'h37);
        vecs[22] = mk(0, 0, 32'h0,        1, 32'h55,       0, 32'h0,        0, 32'hFFFFFFFC, 32'h37);
        vecs[23] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h55);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset imem_req", imem_req, 1'b0);
        check("reset instr_valid", instr_valid, 1'b0);
        check("reset instr", instr, 32'h0);
        check("reset pc_out", pc_out, 32'h0);
        check("reset addr", imem_addr, 32'h0);

        // Directed table, first entry is the first cycle after reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i != 0) @(negedge clk);
            stall       = vecs[i].st;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            imem_valid  = vecs[i].mv;
            imem_rdata  = vecs[i].md;
            #1;
            exp_op = vecs[i].e_ins[6:0];
            check($sformatf("vec%0d imem_req", i), imem_req, vecs[i].e_req);
            check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d instr_valid", i), instr_valid, vecs[i].e_iv);
            check($sformatf("vec%0d pc_out", i), pc_out, vecs[i].e_pco);
            check($sformatf("vec%0d instr", i), instr, vecs[i].e_ins);
            check($sformatf("vec%0d opCode", i), opCode, exp_op);
        end

        // Reset asserted while a request (to 0x4) is outstanding.
        @(negedge clk);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst imem_req", imem_req, 1'b0);
        check("async rst instr_valid", instr_valid, 1'b0);
        check("async rst instr", instr, 32'h0);
        check("async rst opCode", opCode, 7'h0);
        check("async rst pc_out", pc_out, 32'h0);
        check("async rst addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = 32'h99;
        @(negedge clk);
        rst_n = 1'b1;  // late response still on the bus at release
        #1;
        check("post rst req", imem_req, 1'b1);
        check("post rst addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_valid = 1'b0;
        #1;
        check("late resp ignored", instr_valid, 1'b0);
        check("late resp instr", instr, 32'h0);
        check("waiting no req", imem_req, 1'b0);
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = 32'h13;
        @(negedge clk);
        drive_idle();
        #1;
        check("first fetch valid", instr_valid, 1'b1);
        check("first fetch instr", instr, 32'h13);
        check("first fetch pc_out", pc_out, 32'h0);

        // Randomized run against the transaction-level model.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_pcout   = 32'h0;
        m_held    = 1'b0;
        m_out     = 1'b0;
        m_discard = 1'b0;
        pend      = 1'b0;
        cnt       = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n != 0) @(negedge clk);
            resp        = pend && cnt == 0;
            imem_valid  = resp ? 1'b1 : (!pend && $urandom_range(0, 7) == 0);
            imem_rdata  = $urandom;
            stall       = $urandom_range(0, 2) == 0;
            redirect    = $urandom_range(0, 9) == 0;
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                                      : ($urandom & 32'hFFFF_FFFC);
            #1;
            exp_req = !redirect && !m_out && (!m_held || !stall);
            check($sformatf("rnd%0d imem_req", n), imem_req, exp_req);
            if (exp_req) check($sformatf("rnd%0d imem_addr", n), imem_addr, m_pc);
            check($sformatf("rnd%0d instr_valid", n), instr_valid, m_held);
            if (m_held) begin
                exp_op = m_instr[6:0];
                check($sformatf("rnd%0d instr", n), instr, m_instr);
                check($sformatf("rnd%0d pc_out", n), pc_out, m_pcout);
                check($sformatf("rnd%0d opCode", n), opCode, exp_op);
            end

            consumed = m_held && !stall;
            got      = imem_valid && m_out;
            if (redirect) begin
                m_pc   = redirect_pc;
                m_held = 1'b0;
                if (m_out && !got) m_discard = 1'b1;
                else               m_out     = 1'b0;
            end else begin
                if (consumed) m_held = 1'b0;
                if (got) begin
                    if (!m_discard) begin
                        m_held  = 1'b1;
                        m_instr = imem_rdata;
                        m_pcout = m_pc;
                        m_pc    = m_pc + 32'd4;
                    end
                    m_out = 1'b0;
                end
                if (exp_req) begin
                    m_out     = 1'b1;
                    m_discard = 1'b0;
                end
            end

            if (resp)      pend = 1'b0;
            else if (pend) cnt--;
            if (imem_req) begin
                pend = 1'b1;
                cnt  = $urandom_range(1, 3) - 1;
            end
        end

        @(negedge clk);
        drive_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
